// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-master memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

  localparam logic [2:0] SC_BYTE = 3'b001;
  localparam logic [2:0] SC_HALF = 3'b010;
  localparam logic [2:0] SC_WORD = 3'b100;

endpackage

// File: rtl/mem_wen_gen.sv
// Converts a store type and the low address bits into the physical byte-lane write mask.
module mem_wen_gen
  import mem_arb_pkg::*;
(
  input  logic [2:0] storecntrl,
  input  logic [1:0] addr,
  output logic [3:0] wen
);

  // Halfwords wrap around the word, so offset 3 covers lanes 3 and 0.
  always_comb begin
    wen = 4'b0000;
    case (storecntrl)
      SC_BYTE: wen = 4'b0001 << addr;
      SC_HALF: begin
        case (addr)
          2'd0:    wen = 4'b0011;
          2'd1:    wen = 4'b0110;
          2'd2:    wen = 4'b1100;
          default: wen = 4'b1001;
        endcase
      end
      SC_WORD: wen = 4'b1111;
      default: wen = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the core LSU (m0) and the
// UART loader (m1), with a bounded locked-burst mode for m1.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_storecntrl,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_storecntrl,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_storecntrl,
  output logic [3:0]  mem_wen,
  input  logic [31:0] mem_dout
);

  localparam int          CW            = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LIMIT = CW'(MAX_BURST);
  localparam bit          LOCK_ALLOWED  = (MAX_BURST > 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic [CW-1:0] burst_inc;
  master_e       last_grant_q, last_grant_d;
  master_e       resp_owner_q;
  logic          resp_valid_q;

  assign burst_inc = burst_cnt_q + CW'(1);

  // Grants are suppressed while rst is high so every output reads zero during reset.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_grant_d = last_grant_q;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (m0_req && m1_req) begin
            if (last_grant_q == MST_M0) m1_gnt = 1'b1;
            else                        m0_gnt = 1'b1;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
          if (m0_gnt) last_grant_d = MST_M0;
          if (m1_gnt) begin
            last_grant_d = MST_M1;
            if (m1_lock && LOCK_ALLOWED) begin
              state_d     = LOCK1;
              burst_cnt_d = CW'(1);
            end
          end
        end
        LOCK1: begin
          m1_gnt       = m1_req;
          last_grant_d = MST_M1;
          if (m1_gnt) burst_cnt_d = burst_inc;
          if (!m1_lock || !m1_req || (m1_gnt && (burst_inc == BURST_LIMIT))) begin
            state_d     = ARB;
            burst_cnt_d = '0;
          end
        end
        default: begin
          state_d     = ARB;
          burst_cnt_d = '0;
        end
      endcase
    end
  end

  // The winner's request drives the memory port in the grant cycle; idle cycles drive zeros.
  always_comb begin
    mem_en         = m0_gnt | m1_gnt;
    mem_addr       = '0;
    mem_din        = '0;
    mem_storecntrl = '0;
    if (m0_gnt) begin
      mem_addr       = m0_addr;
      mem_din        = m0_wdata;
      mem_storecntrl = m0_storecntrl;
    end else if (m1_gnt) begin
      mem_addr       = m1_addr;
      mem_din        = m1_wdata;
      mem_storecntrl = m1_storecntrl;
    end
  end

  mem_wen_gen u_wen_gen (
    .storecntrl (mem_storecntrl),
    .addr       (mem_addr[1:0]),
    .wen        (mem_wen)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      burst_cnt_q  <= '0;
      last_grant_q <= MST_M1;
      resp_owner_q <= MST_M0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
      resp_owner_q <= m1_gnt ? MST_M1 : MST_M0;
      resp_valid_q <= m0_gnt | m1_gnt;
    end
  end

  // Read data is steered to the master that owned the previous cycle's grant.
  assign m0_rvalid = resp_valid_q && (resp_owner_q == MST_M0);
  assign m1_rvalid = resp_valid_q && (resp_owner_q == MST_M1);
  assign m0_rdata  = m0_rvalid ? mem_dout : '0;
  assign m1_rdata  = m1_rvalid ? mem_dout : '0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 16, maximum consecutive locked grants to m1 before a forced yield.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 m0_req / m1_req  in  1  access request; m0 is the core load/store unit, m1 is the UART loader.
REQ-006 mN_addr  in  32  byte address.
REQ-007 mN_wdata  in  32  store data.
REQ-008 mN_storecntrl  in  3  store type: 001 byte, 010 halfword, 100 word, anything else is a load.
REQ-009 m1_lock  in  1  m1 requests exclusive back-to-back grants.
REQ-010 mN_gnt  out  1  request accepted this cycle (combinational).
REQ-011 mN_rvalid  out  1  read data valid, one cycle after grant.
REQ-012 mN_rdata  out  32  read data.
REQ-013 mem_en  out  1  memory port enable.
REQ-014 mem_addr / mem_din  out  32  address and data to the memory port.
REQ-015 mem_storecntrl  out  3  store type to the memory port.
REQ-016 mem_wen  out  4  physical byte-lane write mask.
REQ-017 mem_dout  in  32  memory read data, valid one cycle after mem_en.

Function
REQ-018 At most one grant SHALL be asserted per cycle, and a grant SHALL be asserted only when the matching request is asserted.
REQ-019 On a grant, the memory outputs SHALL mux the winner's addr, wdata and storecntrl in the same cycle, and mem_en SHALL be 1.
REQ-020 With no grant, mem_en, mem_wen and mem_storecntrl SHALL be 0; mem_addr and mem_din SHALL hold 0.
REQ-021 mem_wen SHALL follow the store type and addr[1:0]:
- byte: 1 << a
- halfword: 0011 rotated left by a (a = 3 gives 1001)
- word: 1111
- load: 0000
REQ-022 The state machine SHALL have two states: ARB and LOCK1.
REQ-023 In ARB with one requester, that requester SHALL be granted.
REQ-024 In ARB with both requesting, the requester not granted most recently SHALL be granted (round-robin via a last_grant register).
REQ-025 ARB SHALL go to LOCK1 when m1 is granted with m1_lock=1; burst_cnt SHALL be set to 1.
REQ-026 In LOCK1, m1_req SHALL be granted, m0 SHALL NOT be granted, and burst_cnt SHALL increment on every m1 grant.
REQ-027 LOCK1 SHALL return to ARB after the cycle in which any of the following holds:
- m1_lock=0
- m1_req=0
- an m1 grant makes burst_cnt equal MAX_BURST
REQ-028 On LOCK1 exit, last_grant SHALL be set to m1, so a waiting m0 wins next.
REQ-029 A forced yield SHALL leave m1 in ARB; m1 may re-enter LOCK1 only after winning arbitration again.
REQ-030 Read response: the cycle after any grant, the owner's mN_rvalid SHALL be 1 and mN_rdata SHALL equal mem_dout. The other master's rdata SHALL be 0.
REQ-031 rvalid SHALL also pulse for granted stores; masters ignore rdata in that case.
REQ-032 Back-to-back grants to either master, or alternating grants, SHALL be supported with no bubble cycles.
REQ-033 Requests SHALL be held until granted; a request withdrawn before grant is dropped without effect.

Reset
REQ-034 While rst=1, the block SHALL hold:
- state = ARB, burst_cnt = 0, last_grant = m1
- the response-owner register cleared
- all outputs 0
REQ-035 An access in flight when rst asserts SHALL produce no rvalid.
REQ-036 On the first clk edge after rst deasserts, normal arbitration SHALL begin, with m0 winning any contention.

Structure
REQ-037 Package mem_arb_pkg SHALL hold:
- the state enum (ARB, LOCK1)
- the storecntrl encodings (SC_BYTE=3'b001, SC_HALF=3'b010, SC_WORD=3'b100)
- the master-ID type
REQ-038 Sub-module mem_wen_gen (inputs: storecntrl, addr[1:0]; output: wen[3:0]) SHALL implement REQ-021.
REQ-039 The registers SHALL be state, burst_cnt (clog2(MAX_BURST+1) bits), last_grant, and resp_owner plus resp_valid.

Verification
REQ-040 After reset, m0_req=m1_req=1 (loads) for 4 cycles -> grants in the order m0, m1, m0, m1; each rvalid goes to the matching master one cycle later with rdata=mem_dout.
REQ-041 m0 stores a halfword to addr 0x0000_0003 with wdata 0x0000_ABCD -> mem_wen=1001, mem_storecntrl=010, mem_din=0x0000_ABCD, mem_en=1 in the grant cycle.
REQ-042 m1_lock=1 with m1_req=1 held and m0_req=1 held, MAX_BURST=16 -> 16 consecutive m1 grants, then m0 granted on the 17th cycle; m0_gnt is 0 throughout the burst.
REQ-043 In LOCK1, m1_lock drops after 3 grants while m0_req=1 -> m0 is granted the next cycle and the state is ARB.
REQ-044 rst asserted in the cycle after an m0 load grant -> m0_rvalid stays 0, and all outputs are 0 while rst is high.
REQ-045 Byte store sweep: addr[1:0]=0..3 -> mem_wen = 0001, 0010, 0100, 1000; a word store gives 1111; a load gives 0000.
